// File: rtl/registerset.sv
// ---------------------------------------------------------------------------
// registerset
//   Register file for the CPU datapath. It holds NUM_REGISTERS words of
//   DataWidth bits and has one synchronous write port and two independent read
//   ports. Both read ports are registered and feed the ALU operands. When a
//   read enable is low, that output is cleared to zero on the next edge.
//
//   A read and a write to the same index on the same edge return the old
//   contents, because nothing bypasses the storage array. A synchronous reset
//   (res_n low) clears the storage and both outputs. During that edge any write
//   or read that is also requested is ignored.
//
// Ports
//   clk        in   1          clock, rising edge
//   res_n      in   1          synchronous reset, active low
//   wr_en      in   1          write enable
//   wr_sel     in   SEL_WIDTH  write index
//   reg_in     in   DataWidth  write data
//   rd_en1     in   1          read enable, port 1
//   rd_sel1    in   SEL_WIDTH  read index, port 1
//   reg_out_1  out  DataWidth  registered read data, port 1
//   rd_en2     in   1          read enable, port 2
//   rd_sel2    in   SEL_WIDTH  read index, port 2
//   reg_out_2  out  DataWidth  registered read data, port 2
// ---------------------------------------------------------------------------
module registerset #(
    parameter int DataWidth     = 8,
    parameter int SEL_WIDTH     = 2,
    parameter int NUM_REGISTERS = 4
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 wr_en,
    input  logic [SEL_WIDTH-1:0] wr_sel,
    input  logic [DataWidth-1:0] reg_in,
    input  logic                 rd_en1,
    input  logic [SEL_WIDTH-1:0] rd_sel1,
    output logic [DataWidth-1:0] reg_out_1,
    input  logic                 rd_en2,
    input  logic [SEL_WIDTH-1:0] rd_sel2,
    output logic [DataWidth-1:0] reg_out_2
);

    // The select fields fully decode the array, so no index can be out of range.
    initial begin : g_param_check
        assert (NUM_REGISTERS == (1 << SEL_WIDTH))
            else $error("registerset: NUM_REGISTERS must equal 2**SEL_WIDTH");
    end

    logic [DataWidth-1:0] r_regs [NUM_REGISTERS];
    logic [DataWidth-1:0] r_out_1;
    logic [DataWidth-1:0] r_out_2;
    logic [DataWidth-1:0] w_rd_data_1;
    logic [DataWidth-1:0] w_rd_data_2;

    // Read muxes look at the pre-edge array contents. This gives the
    // old-value behaviour on a read-during-write.
    always_comb begin
        w_rd_data_1 = rd_en1 ? r_regs[rd_sel1] : '0;
        w_rd_data_2 = rd_en2 ? r_regs[rd_sel2] : '0;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            r_regs[wr_sel] <= reg_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_out_1 <= '0;
            r_out_2 <= '0;
        end else begin
            r_out_1 <= w_rd_data_1;
            r_out_2 <= w_rd_data_2;
        end
    end

    assign reg_out_1 = r_out_1;
    assign reg_out_2 = r_out_2;

endmodule

// File: tb/tb_registerset.sv
// ---------------------------------------------------------------------------
// tb_registerset
//   Directed scoreboard bench for registerset. Each vector drives the inputs
//   for one clock edge and queues the hand-computed outputs expected after
//   that edge. A monitor samples both outputs on every falling edge, pops the
//   matching expectation and compares.
// ---------------------------------------------------------------------------
module tb_registerset;

    localparam int DW = 8;
    localparam int SW = 2;

    logic          clk;
    logic          res_n;
    logic          wr_en;
    logic [SW-1:0] wr_sel;
    logic [DW-1:0] reg_in;
    logic          rd_en1;
    logic [SW-1:0] rd_sel1;
    logic [DW-1:0] reg_out_1;
    logic          rd_en2;
    logic [SW-1:0] rd_sel2;
    logic [DW-1:0] reg_out_2;

    typedef struct {
        int            id;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors;
    int   n_miscompares;
    int   vec_id;

    registerset #(
        .DataWidth    (DW),
        .SEL_WIDTH    (SW),
        .NUM_REGISTERS(4)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .reg_in   (reg_in),
        .rd_en1   (rd_en1),
        .rd_sel1  (rd_sel1),
        .reg_out_1(reg_out_1),
        .rd_en2   (rd_en2),
        .rd_sel2  (rd_sel2),
        .reg_out_2(reg_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each falling edge, check the result of the preceding
    // rising edge against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vectors++;
            if (reg_out_1 !== e.exp1) begin
                n_miscompares++;
                $display("FAIL vec%0d reg_out_1: got %0h expected %0h", e.id, reg_out_1, e.exp1);
            end
            if (reg_out_2 !== e.exp2) begin
                n_miscompares++;
                $display("FAIL vec%0d reg_out_2: got %0h expected %0h", e.id, reg_out_2, e.exp2);
            end
        end
    end

    // Drives the inputs shortly after a falling edge, so the monitor has
    // already consumed the previous result, and queues the expected outputs
    // for the next rising edge.
    task automatic apply(input logic rst_n_v, input logic we, input logic [SW-1:0] ws,
                         input logic [DW-1:0] din,
                         input logic e1, input logic [SW-1:0] s1,
                         input logic e2, input logic [SW-1:0] s2,
                         input logic [DW-1:0] x1, input logic [DW-1:0] x2);
        exp_t e;
        @(negedge clk);
        #1;
        res_n   = rst_n_v;
        wr_en   = we;
        wr_sel  = ws;
        reg_in  = din;
        rd_en1  = e1;
        rd_sel1 = s1;
        rd_en2  = e2;
        rd_sel2 = s2;
        e.id    = vec_id;
        e.exp1  = x1;
        e.exp2  = x2;
        exp_q.push_back(e);
        vec_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        vec_id        = 0;
        res_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = '0;
        reg_in  = '0;
        rd_en1  = 1'b0;
        rd_sel1 = '0;
        rd_en2  = 1'b0;
        rd_sel2 = '0;

        //     rst we ws  din    e1 s1  e2 s2   exp1   exp2
        // Reset, including an ignored write and read request
        apply(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        apply(0, 1, 3, 8'hAA, 1, 3, 1, 3, 8'h00, 8'h00);
        apply(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        apply(1, 0, 0, 8'h00, 1, 3, 1, 3, 8'h00, 8'h00);
        // Writes with both reads disabled
        apply(1, 1, 3, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00);
        apply(1, 1, 2, 8'h0F, 0, 0, 0, 0, 8'h00, 8'h00);
        apply(1, 1, 0, 8'h80, 0, 0, 0, 0, 8'h00, 8'h00);
        // Port 1 reads R3, then drops its enable
        apply(1, 0, 0, 8'h00, 1, 3, 0, 0, 8'hFF, 8'h00);
        apply(1, 0, 0, 8'h00, 0, 3, 0, 0, 8'h00, 8'h00);
        // Write R1 while port 2 reads R0
        apply(1, 1, 1, 8'h03, 0, 0, 1, 0, 8'h00, 8'h80);
        // Both ports on the same register, then on different ones
        apply(1, 0, 0, 8'h00, 1, 2, 1, 2, 8'h0F, 8'h0F);
        apply(1, 0, 0, 8'h00, 1, 1, 1, 3, 8'h03, 8'hFF);
        // Read during write of the same index returns the old value
        apply(1, 1, 2, 8'h5A, 1, 2, 0, 0, 8'h0F, 8'h00);
        apply(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'h5A, 8'h00);
        // Mid-sequence reset that also requests a write and reads
        apply(0, 1, 0, 8'h77, 1, 2, 1, 3, 8'h00, 8'h00);
        apply(1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00);
        apply(1, 0, 0, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00);
        // Write-read on both ports, then port 1 disabled while port 2 holds
        apply(1, 1, 1, 8'hC3, 0, 0, 1, 1, 8'h00, 8'h00);
        apply(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hC3, 8'hC3);
        apply(1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h00, 8'hC3);
        // Every bit position of R0 and R3
        apply(1, 1, 0, 8'h55, 0, 0, 0, 0, 8'h00, 8'h00);
        apply(1, 1, 3, 8'hAA, 1, 0, 1, 3, 8'h55, 8'h00);
        apply(1, 0, 0, 8'h00, 1, 3, 1, 0, 8'hAA, 8'h55);

        // Let the monitor drain the last expectation, within a bounded time.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        if (n_vectors != vec_id) begin
            n_miscompares++;
            $display("FAIL vector_count: checked %0d expected %0d", n_vectors, vec_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
